// File: rtl/alu_result_buffer.sv
// Result FIFO behind alu_32bit: buffers {result, opcode, masked flags} with a
// valid/ready handshake and keeps sticky status flags for software and debug.
module alu_result_buffer #(
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH+1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [31:0]   in_result,
   input  logic [2:0]    in_opcode,
   input  logic          in_zero,
   input  logic          in_carry,
   input  logic          in_overflow,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [31:0]   out_result,
   output logic [2:0]    out_opcode,
   output logic [2:0]    out_flags,
   output logic [2:0]    sticky_flags,
   input  logic          sticky_clr,
   output logic [CW-1:0] count
);

   localparam int AW = $clog2(DEPTH);

   typedef struct packed {
      logic [31:0] result;
      logic [2:0]  opcode;
      logic [2:0]  flags;   // {overflow, carry, zero}
   } entry_t;

   entry_t        mem [DEPTH];
   logic [AW-1:0] wptr, rptr;
   logic          push, pop, arith;
   logic [2:0]    mflags;
   entry_t        head;

   assign in_ready  = (count != CW'(DEPTH));
   assign out_valid = (count != '0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   // Carry and overflow only mean something for ADD/SUB.
   assign arith  = (in_opcode == 3'b000) || (in_opcode == 3'b001);
   assign mflags = {in_overflow & arith, in_carry & arith, in_zero};

   assign head       = mem[rptr];
   assign out_result = head.result;
   assign out_opcode = head.opcode;
   assign out_flags  = head.flags;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (push) begin
            mem[wptr] <= '{result: in_result, opcode: in_opcode, flags: mflags};
            wptr      <= wptr + AW'(1);
         end
         if (pop) rptr <= rptr + AW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else begin
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Clear wins first, so a racing push leaves only its own flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)          sticky_flags <= '0;
      else if (sticky_clr) sticky_flags <= push ? mflags : 3'b000;
      else if (push)       sticky_flags <= sticky_flags | mflags;
   end

endmodule

// File: tb/tb_alu_result_buffer.sv
// Bench for alu_result_buffer: directed scenarios plus random traffic, all
// checked against a queue-based reference model.
module tb_alu_result_buffer;

   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH+1);

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid, in_ready;
   logic [31:0]   in_result;
   logic [2:0]    in_opcode;
   logic          in_zero, in_carry, in_overflow;
   logic          out_valid, out_ready;
   logic [31:0]   out_result;
   logic [2:0]    out_opcode, out_flags, sticky_flags;
   logic          sticky_clr;
   logic [CW-1:0] count;

   alu_result_buffer #(.DEPTH(DEPTH), .CW(CW)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_result(in_result), .in_opcode(in_opcode),
      .in_zero(in_zero), .in_carry(in_carry), .in_overflow(in_overflow),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_opcode(out_opcode), .out_flags(out_flags),
      .sticky_flags(sticky_flags), .sticky_clr(sticky_clr), .count(count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] result;
      logic [2:0]  op;
      logic [2:0]  flags;
   } ent_t;

   ent_t       q[$];
   logic [2:0] sticky_m;
   int         n_cmp = 0;
   int         n_err = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [31:0] r, input logic [2:0] op,
                        input logic z, input logic c, input logic o,
                        input logic ordy, input logic clr);
      in_valid = v; in_result = r; in_opcode = op;
      in_zero = z; in_carry = c; in_overflow = o;
      out_ready = ordy; sticky_clr = clr;
   endtask

   task automatic check_outs();
      chk("count", 64'(count), 64'(q.size()));
      chk("in_ready", 64'(in_ready), 64'(q.size() < DEPTH));
      chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
      chk("sticky", 64'(sticky_flags), 64'(sticky_m));
      if (q.size() > 0) begin
         chk("out_result", 64'(out_result), 64'(q[0].result));
         chk("out_opcode", 64'(out_opcode), 64'(q[0].op));
         chk("out_flags", 64'(out_flags), 64'(q[0].flags));
      end
   endtask

   // Check current outputs, clock once, advance the model with the driven inputs.
   task automatic cycle();
      bit   do_push, do_pop;
      ent_t e;
      check_outs();
      do_push = in_valid && (q.size() < DEPTH);
      do_pop  = out_ready && (q.size() > 0);
      e.result = in_result;
      e.op     = in_opcode;
      e.flags  = (in_opcode inside {3'd0, 3'd1}) ? {in_overflow, in_carry, in_zero}
                                                  : {2'b00, in_zero};
      @(posedge clk); #1;
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(e);
      if (sticky_clr) sticky_m = 3'b000;
      if (do_push) sticky_m = sticky_m | e.flags;
   endtask

   initial begin
      rst_n = 1'b0;
      sticky_m = 3'b000;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // reset then idle
      chk("rst_count", 64'(count), 0);
      chk("rst_out_valid", 64'(out_valid), 0);
      chk("rst_in_ready", 64'(in_ready), 1);
      chk("rst_sticky", 64'(sticky_flags), 0);
      chk("rst_out_result", 64'(out_result), 0);
      cycle();

      // single pass
      drive(1, 32'h8, 3'b000, 0, 0, 0, 1, 0); cycle();
      drive(0, 0, 0, 0, 0, 0, 1, 0);
      chk("single_valid", 64'(out_valid), 1);
      chk("single_result", 64'(out_result), 64'h8);
      chk("single_flags", 64'(out_flags), 0);
      cycle();
      chk("single_drain", 64'(out_valid), 0);

      // fill and stall
      for (int k = 1; k <= 5; k++) begin
         drive(1, 32'(k), 3'b011, 0, 0, 0, 0, 0); cycle();
      end
      chk("fill_count", 64'(count), 4);
      chk("fill_ready", 64'(in_ready), 0);
      for (int k = 1; k <= 4; k++) begin
         drive(0, 0, 0, 0, 0, 0, 1, 0);
         chk("drain_order", 64'(out_result), 64'(k));
         cycle();
      end
      chk("drain_count", 64'(count), 0);
      chk("drain_ready", 64'(in_ready), 1);

      // flag masking (clear sticky first)
      drive(0, 0, 0, 0, 0, 0, 0, 1); cycle();
      drive(1, 32'h00F000F0, 3'b010, 0, 1, 1, 0, 0); cycle();
      chk("mask_and_flags", 64'(out_flags), 0);
      chk("mask_and_sticky", 64'(sticky_flags), 0);
      drive(1, 32'h1, 3'b001, 0, 1, 0, 1, 0); cycle();
      chk("mask_sub_sticky", 64'(sticky_flags), 3'b010);
      drive(0, 0, 0, 0, 0, 0, 1, 0);
      chk("mask_sub_flags", 64'(out_flags), 3'b010);
      cycle();

      // sticky clear race
      drive(1, 32'h0, 3'b000, 1, 0, 0, 1, 1); cycle();
      chk("race_sticky", 64'(sticky_flags), 3'b001);
      drive(0, 0, 0, 0, 0, 0, 1, 1); cycle();
      chk("clr_sticky", 64'(sticky_flags), 0);

      // wrap with concurrent traffic at count=2
      for (int k = 0; k < 2; k++) begin
         drive(1, 32'h100 + 32'(k), 3'b100, 0, 0, 0, 0, 0); cycle();
      end
      for (int k = 2; k < 12; k++) begin
         drive(1, 32'h100 + 32'(k), 3'b100, 0, 0, 0, 1, 0);
         chk("wrap_order", 64'(out_result), 64'(32'h100 + 32'(k - 2)));
         cycle();
         chk("wrap_count", 64'(count), 2);
      end
      drive(1, 32'h200, 3'b111, 0, 0, 0, 0, 0); cycle();
      chk("pre_rst_count", 64'(count), 3);

      // asynchronous reset mid-flight
      drive(0, 0, 0, 0, 0, 0, 1, 0);
      rst_n = 1'b0;
      #1;
      chk("arst_count", 64'(count), 0);
      chk("arst_out_valid", 64'(out_valid), 0);
      chk("arst_out_result", 64'(out_result), 0);
      q.delete();
      sticky_m = 3'b000;
      #1 rst_n = 1'b1;
      repeat (3) cycle();

      // random traffic
      for (int k = 0; k < 400; k++) begin
         drive($urandom_range(0, 3) != 0, $urandom, 3'($urandom_range(0, 7)),
               1'($urandom), 1'($urandom), 1'($urandom),
               $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
         cycle();
      end
      drive(0, 0, 0, 0, 0, 0, 1, 0);
      repeat (DEPTH + 1) cycle();
      check_outs();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/alu_result_buffer.md
Name: alu_result_buffer

Overview:
Downstream stage of alu_32bit. It captures each ALU result, its flags and its opcode into a small FIFO using a valid/ready handshake, so a stalled consumer (writeback or register file) does not lose results. It masks arithmetic-only flags for logic opcodes. It also keeps sticky status flags for software and debug.

Parameters:
DEPTH, 4, number of FIFO entries; power of two, at least 2.
CW, $clog2(DEPTH+1), width of the occupancy count output.

Ports:
clk  input  1  rising-edge clock for all state.
rst_n  input  1  reset, asynchronous and active-low; clears all state.
in_valid  input  1  upstream has an ALU result this cycle.
in_ready  output  1  buffer can accept an entry this cycle.
in_result  input  32  ALU result.
in_opcode  input  3  opcode that produced in_result (000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NAND, 110 NOT, 111 PASS A).
in_zero  input  1  ALU zero flag.
in_carry  input  1  ALU carry_out.
in_overflow  input  1  ALU overflow.
out_valid  output  1  head entry is valid.
out_ready  input  1  consumer takes the head entry this cycle.
out_result  output  32  head entry result.
out_opcode  output  3  head entry opcode.
out_flags  output  3  head entry flags {overflow, carry, zero} after masking.
sticky_flags  output  3  OR of masked {overflow, carry, zero} over all accepted entries since the last clear.
sticky_clr  input  1  synchronous clear of sticky_flags.
count  output  CW  current occupancy, 0 to DEPTH.

Behaviour:
- Reset (rst_n low, asynchronous): count=0, write and read pointers=0, all storage=0, sticky_flags=0. Consequently out_valid=0, out_result=0, out_opcode=0, out_flags=0 and in_ready=1. Reset asserted mid-operation discards all entries; nothing is popped afterwards.
- Push: occurs when in_valid && in_ready. in_ready = (count != DEPTH), derived combinationally from registered count only. It does not depend on out_ready, so there is no pass-through when full.
- Pop: occurs when out_valid && out_ready. out_valid = (count != 0). The out_* signals are a combinational read of the head entry from registered storage.
- Latency: an entry pushed at edge N is visible on out_* after edge N, i.e. one cycle. There is no combinational in-to-out path.
- Simultaneous push and pop: count is unchanged; both pointers advance. When count=0, no pop is possible, so this is push only.
- Pointers are log2(DEPTH) bits and wrap from DEPTH-1 to 0.
- Ordering is strictly FIFO; entries are never reordered or dropped.
- Flag masking at push:
  - stored zero = in_zero for every opcode.
  - stored carry = in_carry, and stored overflow = in_overflow, only when in_opcode is 000 or 001.
  - For all other opcodes, stored carry and overflow are 0.
- Sticky flags: at each push, sticky_flags <= sticky_flags | masked flags.
  - sticky_clr with no push: sticky_flags <= 0.
  - sticky_clr with a simultaneous push: sticky_flags <= that entry's masked flags (clear takes effect first, then the OR).
  - Sticky flags are unaffected by pops.
- Inputs are ignored when in_valid=0 or in_ready=0.
- out_ready while out_valid=0 has no effect.
- Under a continuous push and pop at one per cycle, occupancy holds steady and throughput is one entry per cycle.

Test Plan:
- Reset then idle: rst_n low for 2 cycles, then high -> count=0, out_valid=0, in_ready=1, sticky_flags=000, out_result=0.
- Single pass:
  - Stimulus: out_ready=1; push {result=0x00000008, op=000, zero=0, carry=0, ovf=0}.
  - Response: out_valid=1 exactly one cycle after the push, out_result=0x00000008, out_flags=000; then out_valid=0.
- Fill and stall:
  - Stimulus: out_ready=0; push results 1, 2, 3, 4, 5 on consecutive cycles.
  - Response: count reaches 4 and in_ready=0; the 5th is not accepted.
  - Then out_ready=1 for 4 cycles -> outputs 1, 2, 3, 4 in order, count=0, in_ready=1.
- Flag masking:
  - Push op=010 (AND) with result=0x00F000F0, carry=1, ovf=1, zero=0 -> out_flags=000, sticky unchanged.
  - Push op=001 with carry=1, ovf=0, zero=0 -> out_flags=010, sticky_flags=010.
- Sticky clear race:
  - Precondition: sticky_flags=010.
  - Assert sticky_clr in the same cycle as a push of op=000, zero=1 -> sticky_flags=001 next cycle.
  - sticky_clr alone -> 000.
- Wrap and concurrent traffic, then reset mid-flight:
  - Stream 10 entries with simultaneous push and pop at count=2 -> output order matches input order across pointer wrap; count stays 2.
  - Pulse rst_n low while count=3 -> count=0 and out_valid=0 immediately (asynchronously); no old entries appear afterwards.
